// File: rtl/axi2apb_bridge.sv
// axi2apb_bridge: single-outstanding AXI4-Lite to APB3/APB4 bridge with
// alternating read/write arbitration and a pready timeout.
module axi2apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [2:0]          awprot,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [2:0]          arprot,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr,
    input  logic                pready
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state;
    logic          wr_first;
    logic [CW-1:0] cnt;
    logic [1:0]    resp;
    logic          idle, wr_pend, grant_w, grant_r, timed_out;

    // AW is only taken together with W, so a write needs both valids
    assign idle    = rstn && state == IDLE;
    assign wr_pend = awvalid && wvalid;
    assign grant_w = idle && wr_pend && (!arvalid || wr_first);
    assign grant_r = idle && arvalid && !grant_w;
    assign awready = grant_w;
    assign wready  = grant_w;
    assign arready = grant_r;
    assign psel    = state == SETUP || state == ACCESS;
    assign penable = state == ACCESS;
    assign bvalid  = state == RESP && pwrite;
    assign rvalid  = state == RESP && !pwrite;
    assign bresp   = resp;
    assign rresp   = resp;
    // pready wins on the last allowed cycle, so a late ready still completes normally
    assign timed_out = TIMEOUT != 0 && !pready && (TIMEOUT < 2 || cnt == CW'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_first <= 1'b1;
            cnt      <= '0;
            resp     <= 2'b00;
            rdata    <= '0;
            paddr    <= '0;
            pprot    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            pwrite   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_w || grant_r) begin
                    state  <= SETUP;
                    cnt    <= '0;
                    pwrite <= grant_w;
                    paddr  <= grant_w ? awaddr : araddr;
                    pprot  <= grant_w ? awprot : arprot;
                    pstrb  <= grant_w ? wstrb : '0;
                    if (grant_w) pwdata <= wdata;
                    if (wr_pend && arvalid) wr_first <= !wr_first;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (pready) begin
                    state <= RESP;
                    resp  <= pslverr ? 2'b10 : 2'b00;
                    if (!pwrite) rdata <= prdata;
                end else if (timed_out) begin
                    state <= RESP;
                    resp  <= 2'b10;
                    if (!pwrite) rdata <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (pwrite ? bready : rready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi2apb_bridge.sv
// tb_axi2apb_bridge: vector table, hand-written corner sequences and a randomized
// run checked against a transaction-level model of the bridge.
module tb_axi2apb_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, prdata = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        pslverr = 1'b0, pready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, psel, penable, pwrite;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    int n_checks = 0, n_fail = 0;
    logic [31:0] last_rdata;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        int          waits;
        bit          serr;
        logic [31:0] prd;
        int          rdly;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        int          e_acc;
    } vec_t;

    vec_t tbl[8];

    axi2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr), .pready(pready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {awready, wready, arready, bvalid, rvalid, psel, penable, pwrite}, 8'h0);
        check("rst_addr_data", {paddr, pwdata}, 64'h0);
        check("rst_misc", {pstrb, pprot, bresp, rresp, rdata}, 43'h0);
        @(negedge clk);
        rstn = 1'b1;
        last_rdata = '0;
    endtask

    // Runs one granted transaction from the cycle after the grant to the response handshake,
    // acting as the APB slave and the AXI response sink.
    task automatic xfer(input vec_t v);
        int acc, lat;
        bit bad_rdy, stable;
        logic [3:0] e_strb;
        e_strb = v.w ? v.strb : 4'h0;
        @(negedge clk);
        if (v.w) begin awvalid = 1'b0; wvalid = 1'b0; end
        else arvalid = 1'b0;
        #1;
        bad_rdy = awready | wready | arready;
        check("setup_ctl", {psel, penable, pwrite}, {1'b1, 1'b0, v.w});
        check("setup_paddr", paddr, v.addr);
        check("setup_pprot", pprot, v.prot);
        check("setup_pstrb", pstrb, e_strb);
        if (v.w) check("setup_pwdata", pwdata, v.data);
        lat = 1;
        acc = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (!(psel && penable)) break;
            acc++;
            if (paddr !== v.addr || pwrite !== v.w || pstrb !== e_strb || pprot !== v.prot) stable = 1'b0;
            if (awready | wready | arready) bad_rdy = 1'b1;
            pready = (acc == v.waits + 1);
            pslverr = v.serr;
            prdata = v.prd;
        end
        pready = 1'b0;
        pslverr = 1'b0;
        prdata = $urandom;
        #1;
        check("access_cycles", acc, v.e_acc);
        check("grant_to_valid", lat, v.e_acc + 2);
        check("apb_stable", stable, 1);
        check("resp_valid", {psel, penable, bvalid, rvalid}, {2'b00, v.w, !v.w});
        check("resp_code", v.w ? bresp : rresp, v.e_resp);
        check("rdata", rdata, v.e_rdata);
        stable = 1'b1;
        for (int i = 0; i < v.rdly; i++) begin
            @(negedge clk);
            #1;
            if ({bvalid, rvalid} !== {v.w, !v.w} || (v.w ? bresp : rresp) !== v.e_resp || rdata !== v.e_rdata)
                stable = 1'b0;
            if (awready | wready | arready) bad_rdy = 1'b1;
        end
        check("resp_hold", stable, 1);
        check("ready_outside_idle", bad_rdy, 0);
        if (v.w) bready = 1'b1;
        else rready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        rready = 1'b0;
        #1 check("resp_done", {bvalid, rvalid}, 2'b00);
    endtask

    initial begin
        vec_t v, wv, rv;
        bit wf, wp, rp, gw, busy, bad;
        int ngr, last_c;

        tbl[0] = '{1'b1, 32'h1000_0004, 3'd0, 32'hA5A5_1234, 4'hF, 0,  1'b0, 32'h0,         0, 2'b00, 32'h0,         1};
        tbl[1] = '{1'b0, 32'h1000_1008, 3'd1, 32'h0,         4'h0, 5,  1'b0, 32'hDEAD_BEEF, 3, 2'b00, 32'hDEAD_BEEF, 6};
        tbl[2] = '{1'b1, 32'h1000_0010, 3'd2, 32'h0000_00FF, 4'h1, 0,  1'b1, 32'h0,         0, 2'b10, 32'hDEAD_BEEF, 1};
        tbl[3] = '{1'b0, 32'h1000_1000, 3'd3, 32'h0,         4'h0, 99, 1'b0, 32'h1111_2222, 1, 2'b10, 32'h0,         TO - 1};
        tbl[4] = '{1'b1, 32'h1000_000C, 3'd4, 32'h0000_0003, 4'hC, 99, 1'b0, 32'h0,         0, 2'b10, 32'h0,         TO - 1};
        tbl[5] = '{1'b0, 32'h1000_1004, 3'd5, 32'h0,         4'h0, 2,  1'b1, 32'h1234_5678, 2, 2'b10, 32'h1234_5678, 3};
        tbl[6] = '{1'b0, 32'h1000_1010, 3'd6, 32'h0,         4'h0, 14, 1'b0, 32'hCAFE_F00D, 0, 2'b00, 32'hCAFE_F00D, TO - 1};
        tbl[7] = '{1'b1, 32'h1000_0014, 3'd7, 32'h0BAD_C0DE, 4'h5, 3,  1'b0, 32'h0,         1, 2'b00, 32'hCAFE_F00D, 4};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tbl[i].w) begin
                awaddr = tbl[i].addr; awprot = tbl[i].prot; wdata = tbl[i].data; wstrb = tbl[i].strb;
                awvalid = 1'b1; wvalid = 1'b1;
            end else begin
                araddr = tbl[i].addr; arprot = tbl[i].prot; arvalid = 1'b1;
            end
            #1 check("grant", {awready, wready, arready}, tbl[i].w ? 3'b110 : 3'b001);
            xfer(tbl[i]);
        end

        // both pending continuously: grants must alternate W,R,W,R from reset, 4 cycles apart
        do_reset();
        awaddr = 32'h1000_0020; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awprot = 3'd0;
        araddr = 32'h1000_1020; arprot = 3'd0; prdata = 32'h5555_AAAA;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        pready = 1'b1; bready = 1'b1; rready = 1'b1;
        ngr = 0; busy = 1'b0; bad = 1'b0; last_c = 0;
        for (int c = 0; c < 60 && !(ngr == 4 && !busy); c++) begin
            #1;
            if (busy && (awready | wready | arready)) bad = 1'b1;
            if (awready | arready) begin
                check("arb_order", awready, ngr % 2 == 0);
                check("arb_wready", wready, awready);
                if (ngr > 0) check("arb_spacing", c - last_c, 4);
                last_c = c;
                ngr++;
                busy = 1'b1;
            end
            if ((bvalid && bready) || (rvalid && rready)) busy = 1'b0;
            @(negedge clk);
            if (ngr == 4) begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; end
        end
        pready = 1'b0; bready = 1'b0; rready = 1'b0;
        #1;
        check("arb_grants", ngr, 4);
        check("arb_ready_outside_idle", bad, 0);
        check("arb_drained", {bvalid, rvalid, psel}, 3'b000);

        // AW without W must not be accepted until W arrives
        @(negedge clk);
        awaddr = 32'h1000_0030; awprot = 3'd1; wdata = 32'h7777_8888; wstrb = 4'h3;
        awvalid = 1'b1; wvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (awready | wready | psel) bad = 1'b1;
            @(negedge clk);
        end
        check("aw_without_w", bad, 0);
        wvalid = 1'b1;
        #1 check("w_arrives_grant", {awready, wready}, 2'b11);
        v = '{1'b1, 32'h1000_0030, 3'd1, 32'h7777_8888, 4'h3, 1, 1'b0, 32'h0, 0, 2'b00, 32'h5555_AAAA, 2};
        xfer(v);

        // reset in the middle of an ACCESS phase aborts without a response
        @(negedge clk);
        araddr = 32'h2000_1000; arprot = 3'd2; arvalid = 1'b1;
        #1 check("abort_grant", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        #1 check("abort_in_access", {psel, penable}, 2'b11);
        #1 rstn = 1'b0;
        #1;
        check("abort_ctl", {psel, penable, bvalid, rvalid}, 4'h0);
        check("abort_paddr", paddr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (bvalid | rvalid | psel) bad = 1'b1;
        end
        check("abort_no_response", bad, 0);
        @(negedge clk);
        araddr = 32'h1000_1040; arprot = 3'd0; arvalid = 1'b1;
        #1 check("post_abort_grant", arready, 1);
        v = '{1'b0, 32'h1000_1040, 3'd0, 32'h0, 4'h0, 1, 1'b0, 32'h600D_F00D, 1, 2'b00, 32'h600D_F00D, 2};
        xfer(v);

        // randomized traffic; the losing request stays pending into the next round
        do_reset();
        wf = 1'b1; wp = 1'b0; rp = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (!wp && $urandom_range(1) == 1) begin
                wp = 1'b1;
                wv.w = 1'b1; wv.addr = $urandom; wv.prot = 3'($urandom); wv.data = $urandom; wv.strb = 4'($urandom);
                awaddr = wv.addr; awprot = wv.prot; wdata = wv.data; wstrb = wv.strb;
                awvalid = 1'b1; wvalid = 1'b1;
            end
            if (!rp && (!wp || $urandom_range(1) == 1)) begin
                rp = 1'b1;
                rv.w = 1'b0; rv.addr = $urandom; rv.prot = 3'($urandom); rv.data = '0; rv.strb = '0;
                araddr = rv.addr; arprot = rv.prot; arvalid = 1'b1;
            end
            #1;
            gw = wp && (!rp || wf);
            if (wp && rp) wf = !wf;
            v = gw ? wv : rv;
            check("rand_grant", {awready, wready, arready}, gw ? 3'b110 : 3'b001);
            v.waits = $urandom_range(9) == 0 ? 20 : int'($urandom_range(4));
            v.serr = $urandom_range(3) == 0;
            v.prd = $urandom;
            v.rdly = $urandom_range(3);
            v.e_acc = v.waits >= TO - 1 ? TO - 1 : v.waits + 1;
            v.e_resp = (v.waits >= TO - 1 || v.serr) ? 2'b10 : 2'b00;
            if (!gw) last_rdata = v.waits >= TO - 1 ? 32'h0 : v.prd;
            v.e_rdata = last_rdata;
            xfer(v);
            if (gw) wp = 1'b0;
            else rp = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
